// File: rtl/perlane_tx_scheduler.sv
// Per-lane TX scheduler: scrambler warm-up, 2-entry block buffer, drain-on-disable.
// Optional periodic alignment-marker gaps are built when PERLANE_SCHED_AM_EN is defined.
module perlane_tx_scheduler #(
  parameter int WARMUP_BLOCKS = 64,
  parameter int AM_PERIOD     = 16384,
  parameter int AM_GAP        = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_enable,
  input  logic [255:0] up_txdata,
  input  logic         up_valid,
  output logic         up_ready,
  output logic         scr_enable,
  output logic [255:0] scr_txdata,
  output logic         scr_txdata_valid,
  input  logic         lo_idle,
  output logic [1:0]   ctl_state
);

  localparam int WW = $clog2(WARMUP_BLOCKS + 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_WARM  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t         state_r;
  logic [WW-1:0]  warm_cnt_r;
  logic [255:0]   head_r;
  logic [255:0]   tail_r;
  logic [1:0]     count_r;
  logic [1:0]     count_nxt_s;
  logic           up_ready_r;
  logic           scr_enable_r;
  logic           gap_s;
  logic           valid_s;
  logic           push_s;
  logic           pop_s;
  logic           warm_xfer_s;

  // Downstream valid and the handshake strobes derived from it
  always_comb begin
    valid_s = 1'b0;
    case (state_r)
      ST_WARM:          valid_s = lo_idle;
      ST_RUN, ST_DRAIN: valid_s = (count_r != 2'd0) & lo_idle & ~gap_s;
      default:          valid_s = 1'b0;
    endcase
    push_s      = up_valid & up_ready_r;
    pop_s       = valid_s & ((state_r == ST_RUN) | (state_r == ST_DRAIN));
    warm_xfer_s = valid_s & (state_r == ST_WARM);
  end

  // Buffer occupancy after this cycle's push/pop
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

`ifdef PERLANE_SCHED_AM_EN
  localparam int BW = $clog2(AM_PERIOD + 1);
  localparam int GW = $clog2(AM_GAP + 1);

  logic [BW-1:0] blk_cnt_r;
  logic [GW-1:0] gap_cnt_r;

  assign gap_s = (gap_cnt_r != {GW{1'b0}});

  // Data-block counter and gap timer; a pop never coincides with an open gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_cnt_r <= {BW{1'b0}};
      gap_cnt_r <= {GW{1'b0}};
    end else if ((state_r == ST_OFF) && cfg_enable) begin
      blk_cnt_r <= {BW{1'b0}};
      gap_cnt_r <= {GW{1'b0}};
    end else begin
      if (gap_s) begin
        gap_cnt_r <= gap_cnt_r - GW'(1);
      end
      if (pop_s) begin
        if (blk_cnt_r == BW'(AM_PERIOD - 1)) begin
          blk_cnt_r <= {BW{1'b0}};
          gap_cnt_r <= GW'(AM_GAP);
        end else begin
          blk_cnt_r <= blk_cnt_r + BW'(1);
        end
      end
    end
  end
`else
  // Gap parameters are accepted but have no effect in this build
  assign gap_s = (AM_PERIOD < 0) && (AM_GAP < 0);
`endif

  // Lane control FSM with registered up_ready / scr_enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_OFF;
      warm_cnt_r   <= {WW{1'b0}};
      up_ready_r   <= 1'b0;
      scr_enable_r <= 1'b0;
    end else begin
      case (state_r)
        ST_OFF: begin
          up_ready_r <= 1'b0;
          if (cfg_enable) begin
            state_r      <= ST_WARM;
            warm_cnt_r   <= WW'(WARMUP_BLOCKS);
            scr_enable_r <= 1'b1;
          end else begin
            scr_enable_r <= 1'b0;
          end
        end
        ST_WARM: begin
          if (!cfg_enable) begin
            state_r      <= ST_OFF;
            scr_enable_r <= 1'b0;
            up_ready_r   <= 1'b0;
          end else if (warm_xfer_s) begin
            warm_cnt_r <= warm_cnt_r - WW'(1);
            if (warm_cnt_r == WW'(1)) begin
              state_r    <= ST_RUN;
              up_ready_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!cfg_enable) begin
            state_r    <= ST_DRAIN;
            up_ready_r <= 1'b0;
          end else begin
            up_ready_r <= (count_nxt_s != 2'd2);
          end
        end
        ST_DRAIN: begin
          up_ready_r <= 1'b0;
          // Drain completes even if cfg_enable has come back; OFF always gets a cycle
          if (count_nxt_s == 2'd0) begin
            state_r      <= ST_OFF;
            scr_enable_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_OFF;
          up_ready_r   <= 1'b0;
          scr_enable_r <= 1'b0;
        end
      endcase
    end
  end

  // Shift-style 2-entry buffer; head is zeroed when empty so WARM emits zero blocks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r  <= 256'd0;
      tail_r  <= 256'd0;
      count_r <= 2'd0;
    end else begin
      count_r <= count_nxt_s;
      case ({push_s, pop_s})
        2'b11: head_r <= up_txdata;
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= up_txdata;
          end else begin
            tail_r <= up_txdata;
          end
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_r <= tail_r;
          end else begin
            head_r <= 256'd0;
          end
        end
        default: head_r <= head_r;
      endcase
    end
  end

  assign up_ready         = up_ready_r;
  assign scr_enable       = scr_enable_r;
  assign scr_txdata       = head_r;
  assign scr_txdata_valid = valid_s;
  assign ctl_state        = state_r;

endmodule

// File: tb/tb_perlane_tx_scheduler.sv
// Directed bench for perlane_tx_scheduler (WARMUP_BLOCKS=4, AM_PERIOD=4, AM_GAP=2).
// Gap expectations follow whether PERLANE_SCHED_AM_EN is defined for the build.
module tb_perlane_tx_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_enable;
  logic [255:0] up_txdata;
  logic         up_valid;
  logic         up_ready;
  logic         scr_enable;
  logic [255:0] scr_txdata;
  logic         scr_txdata_valid;
  logic         lo_idle;
  logic [1:0]   ctl_state;

  int checks = 0;
  int errors = 0;
  logic [255:0] sb_q[$];

  perlane_tx_scheduler #(
    .WARMUP_BLOCKS(4),
    .AM_PERIOD(4),
    .AM_GAP(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_enable(cfg_enable),
    .up_txdata(up_txdata),
    .up_valid(up_valid),
    .up_ready(up_ready),
    .scr_enable(scr_enable),
    .scr_txdata(scr_txdata),
    .scr_txdata_valid(scr_txdata_valid),
    .lo_idle(lo_idle),
    .ctl_state(ctl_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Raise cfg_enable from OFF and expect exactly four zero blocks, then RUN
  task automatic bring_up();
    cfg_enable = 1'b1;
    lo_idle    = 1'b1;
    up_valid   = 1'b0;
    #1;
    chk("off_state", 256'(ctl_state), 256'(0));
    cyc();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("warm_state", 256'(ctl_state), 256'(1));
      chk("warm_en", 256'(scr_enable), 256'(1));
      chk("warm_valid", 256'(scr_txdata_valid), 256'(1));
      chk("warm_data", scr_txdata, 256'd0);
      chk("warm_ready", 256'(up_ready), 256'(0));
      cyc();
    end
    #1;
    chk("run_state", 256'(ctl_state), 256'(2));
    chk("run_ready", 256'(up_ready), 256'(1));
    chk("run_valid", 256'(scr_txdata_valid), 256'(0));
  endtask

  // One streaming cycle with a bench-side scoreboard of accepted blocks
  task automatic sb_cycle(input logic uv, input logic [255:0] ud);
    logic [255:0] exp_d;
    up_valid  = uv;
    up_txdata = ud;
    #1;
    chk("idle_gate", 256'(scr_txdata_valid & ~lo_idle), 256'(0));
    if (scr_txdata_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_underrun", 256'(1), 256'(0));
      end else begin
        exp_d = sb_q.pop_front();
        chk("sb_data", scr_txdata, exp_d);
      end
    end
    if (up_valid && up_ready) sb_q.push_back(ud);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         bp_uv[7];
    logic [255:0] bp_d[7];
    logic         bp_li[7];
    logic         bp_ev[7];
    logic [255:0] bp_ed[7];
    logic         bp_er[7];
    logic [255:0] blk_a, blk_b, blk_c, blk_x, blk_y, blk_z;
    logic         exp_v;
    int           budget;

    blk_a = {8{32'hAAAA_0001}};
    blk_b = {8{32'hBBBB_0002}};
    blk_c = {8{32'hCCCC_0003}};
    blk_x = {8{32'h1234_5678}};
    blk_y = {8{32'h9ABC_DEF0}};
    blk_z = {8{32'hDEAD_BEEF}};

    reset      = 1'b1;
    cfg_enable = 1'b0;
    up_valid   = 1'b0;
    up_txdata  = 256'd0;
    lo_idle    = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    chk("rst_ready", 256'(up_ready), 256'(0));
    chk("rst_en", 256'(scr_enable), 256'(0));
    chk("rst_valid", 256'(scr_txdata_valid), 256'(0));
    chk("rst_state", 256'(ctl_state), 256'(0));
    chk("rst_data", scr_txdata, 256'd0);
    cyc();

    // Backpressure: lo_idle 1,1,0,0,1,1,1 while streaming A,B,C
    bring_up();
    bp_uv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bp_d  = '{blk_a, blk_b, blk_c, 256'd0, 256'd0, 256'd0, 256'd0};
    bp_li = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bp_ev = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bp_ed = '{256'd0, blk_a, 256'd0, 256'd0, blk_b, blk_c, 256'd0};
    bp_er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 7; k++) begin
      up_valid  = bp_uv[k];
      up_txdata = bp_d[k];
      lo_idle   = bp_li[k];
      #1;
      chk("bp_valid", 256'(scr_txdata_valid), 256'(bp_ev[k]));
      if (bp_ev[k]) chk("bp_data", scr_txdata, bp_ed[k]);
      chk("bp_ready", 256'(up_ready), 256'(bp_er[k]));
      cyc();
    end
    cfg_enable = 1'b0;
    up_valid   = 1'b0;
    #1;
    chk("bp_run", 256'(ctl_state), 256'(2));
    cyc();
    #1;
    chk("bp_drain", 256'(ctl_state), 256'(3));
    cyc();
    #1;
    chk("bp_off", 256'(ctl_state), 256'(0));
    chk("bp_off_en", 256'(scr_enable), 256'(0));

    // Drain with two buffered blocks and cfg_enable reasserted mid-drain
    bring_up();
    up_valid = 1'b1; up_txdata = blk_x; lo_idle = 1'b0;
    #1; chk("dr_ready0", 256'(up_ready), 256'(1)); cyc();
    up_valid = 1'b1; up_txdata = blk_y; lo_idle = 1'b0;
    #1; chk("dr_ready1", 256'(up_ready), 256'(1)); cyc();
    up_valid = 1'b0; cfg_enable = 1'b0;
    #1; chk("dr_full", 256'(up_ready), 256'(0)); cyc();
    lo_idle = 1'b1; cfg_enable = 1'b1;
    #1;
    chk("dr_state", 256'(ctl_state), 256'(3));
    chk("dr_en", 256'(scr_enable), 256'(1));
    chk("dr_ready", 256'(up_ready), 256'(0));
    chk("dr_v0", 256'(scr_txdata_valid), 256'(1));
    chk("dr_d0", scr_txdata, blk_x);
    cyc();
    #1;
    chk("dr_state1", 256'(ctl_state), 256'(3));
    chk("dr_v1", 256'(scr_txdata_valid), 256'(1));
    chk("dr_d1", scr_txdata, blk_y);
    cyc();
    #1;
    chk("dr_off", 256'(ctl_state), 256'(0));
    chk("dr_off_en", 256'(scr_enable), 256'(0));
    chk("dr_off_v", 256'(scr_txdata_valid), 256'(0));
    cyc();
    #1;
    chk("dr_rewarm", 256'(ctl_state), 256'(1));
    cfg_enable = 1'b0;
    cyc();
    #1;
    chk("dr_abort", 256'(ctl_state), 256'(0));

    // Gaps: continuous traffic, valid pattern from the first RUN cycle
    bring_up();
    for (int i = 0; i < 13; i++) begin
      up_valid  = 1'b1;
      up_txdata = {224'd0, 32'(i + 100)};
      #1;
`ifdef PERLANE_SCHED_AM_EN
      exp_v = (i >= 1) && (((i - 1) % 6) < 4);
`else
      exp_v = (i >= 1);
`endif
      chk("gap_valid", 256'(scr_txdata_valid), 256'(exp_v));
      sb_cycle(1'b1, {224'd0, 32'(i + 100)});
    end
    cfg_enable = 1'b0;
    budget = 0;
    while ((ctl_state != 2'd0) && (budget < 30)) begin
      sb_cycle(1'b0, 256'd0);
      budget++;
    end
    chk("gap_drain_done", 256'(ctl_state), 256'(0));
    chk("gap_sb_empty", 256'(sb_q.size()), 256'(0));

    // Reset mid-RUN with one block buffered
    bring_up();
    up_valid = 1'b1; up_txdata = blk_z; lo_idle = 1'b0;
    #1; chk("rr_ready", 256'(up_ready), 256'(1)); cyc();
    up_valid = 1'b0; lo_idle = 1'b1; reset = 1'b1;
    #1;
    chk("rr_state", 256'(ctl_state), 256'(0));
    chk("rr_valid", 256'(scr_txdata_valid), 256'(0));
    chk("rr_ready0", 256'(up_ready), 256'(0));
    chk("rr_en", 256'(scr_enable), 256'(0));
    chk("rr_data", scr_txdata, 256'd0);
    cyc();
    reset = 1'b0;
    bring_up();
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rr_no_stale", 256'(scr_txdata_valid), 256'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
